// File: rtl/riscv_pkg.sv
// Shared pipeline types used by the data-memory bus bridge.
package riscv_pkg;

  // Bridge sequencing: accept LSU strobe, present request, await response, release pipeline.
  typedef enum logic [1:0] {
    BR_IDLE,
    BR_REQ,
    BR_WAIT,
    BR_DONE
  } bridge_state_e;

  // One latched memory request; the bus side is driven only from this record.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Watchdog counter for the response wait. Cleared when a request is accepted,
// counts every cycle while enabled, and flags the last permitted wait cycle.
module bridge_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  // Clear on request acceptance, otherwise advance once per waiting cycle.
  // The bridge leaves the wait state at LAST_COUNT, so the count never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = enable && (count_reg == LAST_COUNT);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridge from the M-stage LSU strobe interface to a multi-cycle valid/ready
// memory bus. Holds the pipeline via stall_mem until the access completes and
// turns a missing response into a bus_err pulse with ERR_RDATA as load data.
module dmem_bus_bridge
  import riscv_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        stall_mem,
  output logic        bus_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  bridge_state_e state_reg;
  bridge_state_e state_next;
  mem_req_t      req_reg;
  logic          req_valid_reg;
  logic [31:0]   data_rd_reg;
  logic          bus_err_reg;
  logic          accept;
  logic          waiting;
  logic          timeout;

  assign accept  = (state_reg == BR_REQ) && mem_req_ready;
  assign waiting = (state_reg == BR_WAIT);

  bridge_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .enable(waiting),
    .expire(timeout)
  );

  // Next-state selection; a response always wins over an expiring watchdog.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BR_IDLE: if (cs) state_next = BR_REQ;
      BR_REQ:  if (mem_req_ready) state_next = BR_WAIT;
      BR_WAIT: if (mem_rsp_valid || timeout) state_next = BR_DONE;
      BR_DONE: state_next = BR_IDLE;
      default: state_next = BR_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= BR_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the LSU strobe once per access so the bus never sees live LSU inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_reg <= '0;
    end else if ((state_reg == BR_IDLE) && cs) begin
      req_reg <= '{we: wr, be: mask, addr: addr, wdata: data_wr};
    end
  end

  // Request valid is high for exactly the cycles spent in the request state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid_reg <= 1'b0;
    end else begin
      req_valid_reg <= (state_next == BR_REQ);
    end
  end

  // Completion data: load data, zero for stores, or the error pattern on timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_rd_reg <= '0;
    end else if (waiting) begin
      if (mem_rsp_valid) begin
        data_rd_reg <= req_reg.we ? 32'h0 : mem_rdata;
      end else if (timeout) begin
        data_rd_reg <= ERR_RDATA;
      end
    end
  end

  // Single-cycle abort flag, visible during the completion cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err_reg <= 1'b0;
    end else begin
      bus_err_reg <= waiting && !mem_rsp_valid && timeout;
    end
  end

  // Stall is combinational so the very first M-stage cycle already freezes the pipe.
  assign stall_mem = ((state_reg == BR_IDLE) && cs)
                   || (state_reg == BR_REQ)
                   || (state_reg == BR_WAIT);

  assign data_rd       = data_rd_reg;
  assign bus_err       = bus_err_reg;
  assign mem_req_valid = req_valid_reg;
  assign mem_we        = req_reg.we;
  assign mem_be        = req_reg.be;
  assign mem_addr      = req_reg.addr;
  assign mem_wdata     = req_reg.wdata;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: the driver pushes expected bus requests
// and expected completions; a negedge monitor pops and compares them.
module tb_dmem_bus_bridge;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        stall_mem;
  logic        bus_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  dmem_bus_bridge #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (ERR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cs           (cs),
    .wr           (wr),
    .mask         (mask),
    .addr         (addr),
    .data_wr      (data_wr),
    .data_rd      (data_rd),
    .stall_mem    (stall_mem),
    .bus_err      (bus_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic [7:0]  stall;
  } rsp_exp_t;

  req_exp_t    req_q[$];
  rsp_exp_t    rsp_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] dev_mem[64];
  logic [31:0] last_data;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_txn    = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endfunction

  function automatic void fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired, got no event expected event", name);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  int       stall_cnt = 0;
  bit       prev_wait = 0;
  req_exp_t prev_req;

  always @(negedge clk) begin
    req_exp_t cur;
    req_exp_t rq;
    rsp_exp_t rs;
    cur = '{we: mem_we, be: mem_be, addr: mem_addr, wdata: mem_wdata};
    if (!rst) begin
      stall_cnt = 0;
      prev_wait = 0;
    end else begin
      if (prev_wait) check("req_stable", {mem_req_valid, cur}, {1'b1, prev_req});
      prev_wait = mem_req_valid && !mem_req_ready;
      prev_req  = cur;
      if (mem_req_valid && mem_req_ready) begin
        if (req_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_req: got addr %0h expected no request", mem_addr);
        end else begin
          rq = req_q.pop_front();
          check("req_fields", cur, rq);
        end
      end
      if (cs && stall_mem) begin
        stall_cnt++;
      end else if (cs && !stall_mem) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          rs = rsp_q.pop_front();
          n_txn++;
          $display("txn %0d addr=%08h data_rd=%08h bus_err=%0b stall=%0d", n_txn, rs.addr, data_rd, bus_err, stall_cnt);
          check("data_rd", data_rd, rs.data);
          check("bus_err", bus_err, rs.err);
          check("stall_cycles", stall_cnt, rs.stall);
        end
        stall_cnt = 0;
      end
      if (bus_err && !(cs && !stall_mem)) check("bus_err_stray", bus_err, 1'b0);
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input logic w, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d,
                           input int rw, input int rd, input bit drop, input bit spur);
    req_exp_t    rq;
    rsp_exp_t    rs;
    int          idx;
    int          guard;
    logic [31:0] rsp_data;
    idx      = int'(a[7:2]);
    rq       = '{we: w, be: m, addr: a, wdata: d};
    rs.addr  = a;
    rs.err   = drop;
    rs.stall = 8'(2 + rw + (drop ? TO : rd));
    if (drop)   rs.data = ERR;
    else if (w) rs.data = 32'h0;
    else        rs.data = ref_mem[idx];
    if (w) ref_mem[idx] = merge(ref_mem[idx], d, m);
    req_q.push_back(rq);
    rsp_q.push_back(rs);
    last_data = rs.data;

    cs = 1'b1; wr = w; mask = m; addr = a; data_wr = d;
    mem_req_ready = 1'b0;
    step();
    guard = 0;
    while (!mem_req_valid && guard < 5) begin step(); guard++; end
    if (!mem_req_valid) fail_bound("req_valid_wait");
    for (int i = 0; i < rw; i++) begin
      if (spur && i == 0) begin mem_rsp_valid = 1'b1; mem_rdata = $urandom; end
      step();
      mem_rsp_valid = 1'b0;
    end
    // memory device: accept, perform write or fetch read data
    mem_req_ready = 1'b1;
    rsp_data = dev_mem[int'(mem_addr[7:2])];
    if (mem_we) dev_mem[int'(mem_addr[7:2])] = merge(rsp_data, mem_wdata, mem_be);
    step();
    mem_req_ready = 1'b0;
    repeat (rd - 1) step();
    if (!drop) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = w ? $urandom : rsp_data;
      step();
      mem_rsp_valid = 1'b0;
    end
    guard = 0;
    while (stall_mem && guard < TO + 8) begin step(); guard++; end
    if (stall_mem) fail_bound("done_wait");
    step();
    cs = 1'b0;
  endtask

  // Response on an idle bus must be ignored.
  task automatic stray_rsp(input string name);
    mem_rsp_valid = 1'b1;
    mem_rdata     = $urandom;
    step();
    mem_rsp_valid = 1'b0;
    step();
    check({name, "_data_rd"}, data_rd, last_data);
    check({name, "_quiet"}, {stall_mem, mem_req_valid, bus_err}, 3'b000);
  endtask

  req_exp_t    rst_rq;
  logic        rw_w;
  logic [3:0]  rw_m;
  logic [31:0] rw_a;
  logic [31:0] rw_d;
  int          rw_rw;
  int          rw_rd;
  bit          rw_drop;
  bit          rw_spur;

  initial begin
    rst = 1'b0; cs = 1'b0; wr = 1'b0; mask = 4'h0; addr = 32'h0; data_wr = 32'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    last_data = 32'h0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      dev_mem[i] = ref_mem[i];
    end
    ref_mem[16] = 32'h1234_5678;
    dev_mem[16] = 32'h1234_5678;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {data_rd, stall_mem, bus_err, mem_req_valid}, 35'h0);
    check("reset_req_regs", {mem_we, mem_be, mem_addr, mem_wdata}, 69'h0);
    rst = 1'b1;
    step();

    // zero-wait load, then store with ready held off two cycles
    do_access(1'b0, 4'hF, 32'h40, 32'h0, 0, 1, 1'b0, 1'b0);
    do_access(1'b1, 4'b0011, 32'h80, 32'h0000_ABCD, 2, 1, 1'b0, 1'b0);
    // back-to-back load then store to 0x44, then read it back
    do_access(1'b0, 4'hF, 32'h40, 32'h0, 0, 1, 1'b0, 1'b0);
    do_access(1'b1, 4'hF, 32'h44, 32'hCAFE_F00D, 0, 1, 1'b0, 1'b0);
    do_access(1'b0, 4'hF, 32'h44, 32'h0, 0, 1, 1'b0, 1'b0);
    do_access(1'b0, 4'hF, 32'h80, 32'h0, 1, 2, 1'b0, 1'b0);
    // response on the last permitted wait cycle still succeeds
    do_access(1'b0, 4'hF, 32'h48, 32'h0, 0, TO, 1'b0, 1'b0);
    // timeout, then a late response that must be ignored
    do_access(1'b0, 4'hF, 32'h4C, 32'h0, 1, 1, 1'b1, 1'b0);
    stray_rsp("late_rsp");
    stray_rsp("idle_rsp");
    // spurious response while the request is still pending
    do_access(1'b0, 4'hF, 32'h50, 32'h0, 2, 1, 1'b0, 1'b1);

    // asynchronous reset in the middle of the response wait
    rst_rq = '{we: 1'b0, be: 4'hF, addr: 32'h54, wdata: 32'h0};
    req_q.push_back(rst_rq);
    cs = 1'b1; wr = 1'b0; mask = 4'hF; addr = 32'h54; data_wr = 32'h0;
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    step();
    step();
    #2;
    cs  = 1'b0;
    rst = 1'b0;
    #1;
    check("midreset_outputs", {data_rd, stall_mem, bus_err, mem_req_valid}, 35'h0);
    check("midreset_req_regs", {mem_we, mem_be, mem_addr, mem_wdata}, 69'h0);
    last_data = 32'h0;
    step();
    step();
    rst = 1'b1;
    step();
    do_access(1'b0, 4'hF, 32'h54, 32'h0, 0, 1, 1'b0, 1'b0);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      rw_w    = 1'($urandom_range(0, 1));
      rw_m    = rw_w ? 4'($urandom_range(1, 15)) : 4'hF;
      rw_a    = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      rw_d    = $urandom;
      rw_rw   = $urandom_range(0, 3);
      rw_rd   = $urandom_range(1, 4);
      rw_drop = !rw_w && ($urandom_range(0, 9) == 0);
      rw_spur = (rw_rw > 0) && ($urandom_range(0, 3) == 0);
      do_access(rw_w, rw_m, rw_a, rw_d, rw_rw, rw_rd, rw_drop, rw_spur);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) step();
    end

    repeat (3) step();
    check("req_queue_drained", req_q.size(), 0);
    check("rsp_queue_drained", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
